// File: rtl/memory_pkg.sv
// Shared types for the line-granular backing memory.
// Latency: n/a (types only).
// Backpressure: n/a.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    GAP
  } mem_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } mem_port_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } mem_op_t;

endpackage

// File: rtl/main_memory_array.sv
// Single-port synchronous line store with a registered read port.
// Latency: read data appears one clock after rd_en; write commits at the clock edge.
// Backpressure: none; the caller never issues a read and a write in the same cycle.
module main_memory_array
  import memory_pkg::*;
#(
  parameter int LINE_W = 128,
  parameter int LINES  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  idx,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [LINE_W-1:0] wr_dat,
  output logic [LINE_W-1:0] rd_dat
);

  logic [LINE_W-1:0] mem_q [LINES];
  logic [LINE_W-1:0] rd_dat_q;

  // Storage is deliberately not reset: contents survive a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat_q <= mem_q[idx];
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/main_memory.sv
// Backing memory answering imem/dmem line requests; dmem wins arbitration, one request in flight.
// Latency: ready pulses MEM_LATENCY cycles after accept, then one GAP cycle before the next accept.
// Backpressure: requester holds enables/addr/data until ready; MAIN_MEMORY_TRACE_EN adds a RESP trace.
module main_memory
  import memory_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LINES       = 1024,
  parameter int MEM_LATENCY     = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_imem_read_en,
  input  logic                       in_imem_write_en,
  input  logic [31:0]                in_imem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_imem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_imem_read_data,
  output logic                       out_imem_ready,
  input  logic                       in_dmem_read_en,
  input  logic                       in_dmem_write_en,
  input  logic [31:0]                in_dmem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dmem_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dmem_read_data,
  output logic                       out_dmem_ready
);

  localparam int OFF = $clog2(CACHE_LINE_SIZE / 8);
  localparam int IDX = $clog2(MEM_LINES);
  localparam int CW  = $clog2(MEM_LATENCY + 1);

  typedef logic [CACHE_LINE_SIZE-1:0] line_t;

  mem_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  mem_port_t      port_q, port_d;
  mem_op_t        op_q, op_d;
  logic [IDX-1:0] idx_q, idx_d;
  line_t          wdat_q, wdat_d;
  logic           i_rdy_q, i_rdy_d;
  logic           d_rdy_q, d_rdy_d;
  line_t          i_hold_q, i_hold_d;
  line_t          d_hold_q, d_hold_d;

  logic           i_req, d_req;
  mem_port_t      sel_port;
  mem_op_t        sel_op;
  logic [31:0]    sel_addr;
  logic [IDX-1:0] sel_idx;
  line_t          sel_wdat;

  logic [IDX-1:0] arr_idx;
  logic           arr_rd_en;
  logic           arr_wr_en;
  line_t          arr_rd_dat;
  line_t          resp_dat;

  // Address offset bits and bits above the index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_imem_addr, in_dmem_addr};

  // Fixed-priority pick of the candidate request: dmem over imem, write over read.
  always_comb begin
    i_req    = in_imem_read_en | in_imem_write_en;
    d_req    = in_dmem_read_en | in_dmem_write_en;
    sel_port = d_req ? PORT_D : PORT_I;
    sel_op   = (d_req ? in_dmem_write_en : in_imem_write_en) ? OP_WRITE : OP_READ;
    sel_addr = d_req ? in_dmem_addr : in_imem_addr;
    sel_idx  = sel_addr[OFF +: IDX];
    sel_wdat = d_req ? in_dmem_write_data : in_imem_write_data;
  end

  // Request FSM: accept, count down the latency, respond, then one dead cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    op_d     = op_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    i_hold_d = i_hold_q;
    d_hold_d = d_hold_q;
    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          port_d = sel_port;
          op_d   = sel_op;
          idx_d  = sel_idx;
          wdat_d = sel_wdat;
          if (MEM_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(MEM_LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = GAP;
        if (port_q == PORT_D) begin
          d_hold_d = resp_dat;
        end else begin
          i_hold_d = resp_dat;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready pulses are registered on the edge that enters RESP.
  always_comb begin
    i_rdy_d = (state_d == RESP) && (port_d == PORT_I);
    d_rdy_d = (state_d == RESP) && (port_d == PORT_D);
  end

  // Array is read on the edge entering RESP (incoming index when that edge is the
  // accept edge) and written on the edge leaving RESP, so the two never collide and
  // a reset before RESP discards a pending write.
  always_comb begin
    arr_idx   = (state_q == IDLE) ? sel_idx : idx_q;
    arr_rd_en = (state_d == RESP) && (op_d == OP_READ);
    arr_wr_en = (state_q == RESP) && (op_q == OP_WRITE);
    resp_dat  = (op_q == OP_WRITE) ? wdat_q : arr_rd_dat;
  end

  main_memory_array #(
    .LINE_W (CACHE_LINE_SIZE),
    .LINES  (MEM_LINES),
    .IDX_W  (IDX)
  ) u_array (
    .clk    (clk),
    .idx    (arr_idx),
    .rd_en  (arr_rd_en),
    .wr_en  (arr_wr_en),
    .wr_dat (wdat_q),
    .rd_dat (arr_rd_dat)
  );

  // State and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= PORT_I;
      op_q     <= OP_READ;
      idx_q    <= '0;
      wdat_q   <= '0;
      i_rdy_q  <= 1'b0;
      d_rdy_q  <= 1'b0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      wdat_q   <= wdat_d;
      i_rdy_q  <= i_rdy_d;
      d_rdy_q  <= d_rdy_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  // During RESP the selected port shows the line straight from the array's read
  // register (or the latched write line); otherwise each port shows its held line.
  // Both sources are flops, so there is no input-to-output path.
  always_comb begin
    out_imem_ready     = i_rdy_q;
    out_dmem_ready     = d_rdy_q;
    out_imem_read_data = (state_q == RESP && port_q == PORT_I) ? resp_dat : i_hold_q;
    out_dmem_read_data = (state_q == RESP && port_q == PORT_D) ? resp_dat : d_hold_q;
  end

`ifdef MAIN_MEMORY_TRACE_EN
  // Trace every completed request.
  always @(posedge clk) begin
    if (reset && state_q == RESP) begin
      $display("%0t main_memory %s %s addr=0x%08h data=0x%h", $time,
               (port_q == PORT_D) ? "D" : "I", (op_q == OP_WRITE) ? "W" : "R",
               32'(idx_q) << OFF, resp_dat);
    end
  end
`endif

endmodule

// File: tb/tb_main_memory.sv
// Directed bench for main_memory: latency, arbitration, aliasing, reset abort, latency-1 build.
// Latency: checks ready at T+MEM_LATENCY and re-accept after the GAP cycle.
// Backpressure: requester model holds enables until ready, then drops them.
module tb_main_memory;

  typedef logic [127:0] line_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // MEM_LATENCY = 5 instance
  logic        i_re, i_we, d_re, d_we;
  logic [31:0] i_addr, d_addr;
  line_t       i_wd, d_wd, i_rd, d_rd;
  logic        i_rdy, d_rdy;

  // MEM_LATENCY = 1 instance (only the data port is exercised)
  logic        e_re, e_we, x_re, x_we;
  logic [31:0] e_addr, x_addr;
  line_t       e_wd, x_wd, e_rd, x_rd;
  logic        e_rdy, x_rdy;

  main_memory #(.CACHE_LINE_SIZE(128), .MEM_LINES(1024), .MEM_LATENCY(5)) dut (
    .clk(clk), .reset(reset),
    .in_imem_read_en(i_re), .in_imem_write_en(i_we), .in_imem_addr(i_addr),
    .in_imem_write_data(i_wd), .out_imem_read_data(i_rd), .out_imem_ready(i_rdy),
    .in_dmem_read_en(d_re), .in_dmem_write_en(d_we), .in_dmem_addr(d_addr),
    .in_dmem_write_data(d_wd), .out_dmem_read_data(d_rd), .out_dmem_ready(d_rdy)
  );

  main_memory #(.CACHE_LINE_SIZE(128), .MEM_LINES(1024), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_imem_read_en(x_re), .in_imem_write_en(x_we), .in_imem_addr(x_addr),
    .in_imem_write_data(x_wd), .out_imem_read_data(x_rd), .out_imem_ready(x_rdy),
    .in_dmem_read_en(e_re), .in_dmem_write_en(e_we), .in_dmem_addr(e_addr),
    .in_dmem_write_data(e_wd), .out_dmem_read_data(e_rd), .out_dmem_ready(e_rdy)
  );

  int n_vec = 0;
  int n_err = 0;

  localparam line_t D0  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam line_t A80 = 128'hDEADBEEF_00000080_CAFEF00D_11112222;
  localparam line_t B80 = 128'hBAADBAAD_BAADBAAD_BAADBAAD_BAADBAAD;
  localparam line_t C10 = 128'h00000100_FEEDFACE_13572468_A5A5A5A5;
  localparam line_t X40 = 128'h55AA55AA_0F0F0F0F_F0F0F0F0_12345678;

  task automatic check_vec(input string tag, input line_t got, input line_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the latency-5 instance: waits (bounded) for ready, checks
  // latency and data, drops the request, and checks the pulse is one cycle.
  task automatic xact(input bit is_d, input bit wr, input logic [31:0] a,
                      input line_t wd, input line_t exp_rd, input string tag);
    int cyc;
    bit seen;
    if (is_d) begin
      d_we = wr; d_re = !wr; d_addr = a; d_wd = wd;
    end else begin
      i_we = wr; i_re = !wr; i_addr = a; i_wd = wd;
    end
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 30) begin
      tick();
      cyc++;
      seen = is_d ? d_rdy : i_rdy;
    end
    check_vec({tag, ".lat"}, line_t'(cyc), line_t'(5));
    check_vec({tag, ".dat"}, is_d ? d_rd : i_rd, exp_rd);
    d_we = 1'b0; d_re = 1'b0; i_we = 1'b0; i_re = 1'b0;
    tick();
    check_vec({tag, ".pulse"}, line_t'(is_d ? d_rdy : i_rdy), line_t'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int d_first, d_cnt, i_first, i_cnt, rc;
    int r [2];
    line_t dat_d, dat_i;

    reset = 1'b0;
    i_re = 0; i_we = 0; i_addr = 0; i_wd = '0;
    d_re = 0; d_we = 0; d_addr = 0; d_wd = '0;
    e_re = 0; e_we = 0; e_addr = 0; e_wd = '0;
    x_re = 0; x_we = 0; x_addr = 0; x_wd = '0;

    #12;
    check_vec("rst.d_rdy", line_t'(d_rdy), line_t'(0));
    check_vec("rst.i_rdy", line_t'(i_rdy), line_t'(0));
    check_vec("rst.d_rd",  d_rd, '0);
    check_vec("rst.i_rd",  i_rd, '0);
    check_vec("rst.e_rdy", line_t'(e_rdy), line_t'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    // write then read back, offset and alias checks
    xact(1'b1, 1'b1, 32'h40,   D0, D0, "dwr40");
    check_vec("ihold0", i_rd, '0);
    xact(1'b1, 1'b0, 32'h40,   '0, D0, "drd40");
    xact(1'b1, 1'b0, 32'h4C,   '0, D0, "off4c");
    xact(1'b1, 1'b0, 32'h4040, '0, D0, "alias");
    xact(1'b0, 1'b1, 32'h100, C10, C10, "iwr100");
    check_vec("dhold", d_rd, D0);
    xact(1'b1, 1'b1, 32'h80,  A80, A80, "dwr80");

    // simultaneous reads: dmem first, imem after the GAP
    d_re = 1; d_addr = 32'h80; i_re = 1; i_addr = 32'h100;
    d_first = 0; d_cnt = 0; i_first = 0; i_cnt = 0; dat_d = '0; dat_i = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (d_rdy) begin
        if (d_first == 0) d_first = c;
        d_cnt++; dat_d = d_rd; d_re = 0;
      end
      if (i_rdy) begin
        if (i_first == 0) i_first = c;
        i_cnt++; dat_i = i_rd; i_re = 0;
      end
    end
    check_vec("arb.d_at", line_t'(d_first), line_t'(5));
    check_vec("arb.d_cnt", line_t'(d_cnt), line_t'(1));
    check_vec("arb.i_at", line_t'(i_first), line_t'(12));
    check_vec("arb.i_cnt", line_t'(i_cnt), line_t'(1));
    check_vec("arb.d_dat", dat_d, A80);
    check_vec("arb.i_dat", dat_i, C10);

    // imem read held through GAP is a second request
    i_re = 1; i_addr = 32'h100; rc = 0; r[0] = 0; r[1] = 0;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (i_rdy) begin
        if (rc < 2) r[rc] = c;
        rc++;
      end
    end
    i_re = 0;
    tick();
    check_vec("hold.cnt", line_t'(rc), line_t'(2));
    check_vec("hold.r1", line_t'(r[0]), line_t'(5));
    check_vec("hold.r2", line_t'(r[1]), line_t'(12));
    check_vec("hold.dat", i_rd, C10);

    // latency-1 instance
    e_we = 1; e_addr = 32'h40; e_wd = X40;
    tick();
    check_vec("l1w.rdy", line_t'(e_rdy), line_t'(1));
    check_vec("l1w.dat", e_rd, X40);
    e_we = 0;
    tick();
    check_vec("l1w.pulse", line_t'(e_rdy), line_t'(0));
    tick();
    e_re = 1; e_addr = 32'h40; rc = 0; r[0] = 0; r[1] = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (e_rdy) begin
        if (rc < 2) r[rc] = c;
        rc++;
      end
    end
    e_re = 0;
    tick();
    check_vec("l1r.cnt", line_t'(rc), line_t'(2));
    check_vec("l1r.r1", line_t'(r[0]), line_t'(1));
    check_vec("l1r.r2", line_t'(r[1]), line_t'(4));
    check_vec("l1r.dat", e_rd, X40);

    // reset during WAIT of a write aborts it
    d_we = 1; d_addr = 32'h80; d_wd = B80;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_vec("rstw.d_rdy", line_t'(d_rdy), line_t'(0));
    check_vec("rstw.d_rd", d_rd, '0);
    check_vec("rstw.i_rd", i_rd, '0);
    d_we = 0;
    @(negedge clk);
    reset = 1'b1;
    rc = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (d_rdy) rc++;
    end
    check_vec("rstw.noready", line_t'(rc), line_t'(0));
    xact(1'b1, 1'b0, 32'h80, '0, A80, "rst_rd80");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_memory.md
# main_memory

Line-granular backing memory that answers the core's instruction-side and data-side cache-line requests: the responder end of the `imem`/`dmem` read/write/ready interface driven by the fetch and cache stages. It arbitrates the two request ports onto one storage array, applies a fixed access latency, and returns a one-cycle `ready` pulse with the line data. It sits outside `core` in the top-level/testbench and feeds `in_imem_*` and `in_dmem_*` directly.

## Interface
- `CACHE_LINE_SIZE`, 128: line width in bits; multiple of 8, power of two.
- `MEM_LINES`, 1024: number of lines stored; power of two.
- `MEM_LATENCY`, 5: cycles from accept to `ready`; must be ≥1.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_imem_read_en` / `in_imem_write_en` in 1: instruction-port request.
- `in_imem_addr` in 32: byte address.
- `in_imem_write_data` in CACHE_LINE_SIZE: line to write.
- `out_imem_read_data` out CACHE_LINE_SIZE: returned line.
- `out_imem_ready` out 1: one-cycle completion pulse.
- `in_dmem_read_en`, `in_dmem_write_en`, `in_dmem_addr`, `in_dmem_write_data`, `out_dmem_read_data`, `out_dmem_ready`: data port, same widths and meaning.

## Operation
- States: IDLE, WAIT, RESP, GAP. One request in flight total.
- IDLE: if either port has `read_en|write_en`, accept one: dmem has fixed priority over imem. Latch port, op, line index, write data. Go to WAIT (counter = MEM_LATENCY-1) or, if MEM_LATENCY==1, directly to RESP.
- Both enables on one port: treated as a write.
- WAIT: decrement counter; at 1 go to RESP.
- RESP: assert selected port's `ready` for exactly one cycle; read: `read_data` = array[index]; write: array[index] updated at end of RESP, `read_data` = written line. Go to GAP.
- GAP: one cycle, no acceptance (lets requester drop enable after seeing `ready`). Go to IDLE.
- Line index = `addr[OFF +: IDX]`, OFF = log2(CACHE_LINE_SIZE/8), IDX = log2(MEM_LINES); low offset bits ignored, upper bits ignored (address aliases/wraps).
- Requester holds addr/data stable until `ready`; responder uses latched copies only, so changes after accept have no effect.
- Unselected port's `ready` stays 0; its `read_data` holds last value.
- Reset (any state): state→IDLE, both `ready`=0, both `read_data`=0, in-flight request dropped (pending write not committed). Array contents not reset.

## Timing
- Request present in IDLE cycle T → `ready` high in cycle T+MEM_LATENCY, `read_data` valid same cycle.
- GAP at T+MEM_LATENCY+1; next accept earliest at T+MEM_LATENCY+2.
- All outputs registered; no combinational input→output path.
- Losing port waits; an enable still high in IDLE after GAP is a new request.

## Configuration
- `MAIN_MEMORY_TRACE_EN` defined: on every RESP cycle `$display` of time, port (I/D), op (R/W), byte address of line, data. Not defined: no trace code compiled; RTL behaviour identical.

## Structure
- Package `memory_pkg`: `mem_state_t` enum {IDLE, WAIT, RESP, GAP}, `mem_port_t` enum {PORT_I, PORT_D}, `mem_op_t` {OP_READ, OP_WRITE}.
- Sub-module `main_memory_array`: single-port synchronous line array (index, write enable, write data, registered read data); FSM, arbitration, latency counter in `main_memory`.

## Test plan
- dmem write 0x40 data 128'h0123…CDEF at T (MEM_LATENCY=5) → `out_dmem_ready` only at T+5; then dmem read 0x40 → same line returned with `ready`.
- imem and dmem read both asserted at T → dmem `ready` at T+5, imem accepted T+7, imem `ready` at T+12; ready pulses exactly one cycle each.
- Read 0x4C after line 0x40 written → identical data (offset ignored); read 0x4040 with MEM_LINES=1024 → aliases line 0x40.
- MEM_LATENCY=1: dmem read at T → `ready` at T+1, next accept at T+3.
- Assert `reset` low during WAIT of a write to 0x80 → no `ready`, outputs zero; after release read 0x80 → old contents, full latency.
- imem `read_en` held high through GAP → re-accepted at T+7 as a second request, second `ready` at T+12.
